// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready
// handshakes on both sides and a saturating completed-operation counter.
//
// Ports:
//   clk       - clock; all state changes on the rising edge
//   rst_n     - synchronous active-low reset
//   in_valid  - upstream presents an operation (a, b, op)
//   in_ready  - block can accept an operation this cycle (combinational)
//   a, b      - WIDTH-bit operands
//   op        - operation select: AND, NAND, OR, NOR, XOR, XNOR, NOT a, pass a
//   out_valid - result presented on r/zero/ones
//   out_ready - downstream accepts the result
//   r         - WIDTH-bit result
//   zero      - r is all zeros
//   ones      - r is all ones
//   op_count  - completed output handshakes, saturating at all-ones
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             ones,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_NAND = 3'b001,
    OP_OR   = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  // Stage 1: captured operands
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] b1_q, b1_d;
  op_e              op1_q, op1_d;

  // Stage 2: result and flags
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ld1, ld2;
  logic [WIDTH-1:0] res;

  always_comb begin
    ld2 = !v2_q || out_ready;
    ld1 = !v1_q || ld2;

    unique case (op1_q)
      OP_AND:  res = a1_q & b1_q;
      OP_NAND: res = ~(a1_q & b1_q);
      OP_OR:   res = a1_q | b1_q;
      OP_NOR:  res = ~(a1_q | b1_q);
      OP_XOR:  res = a1_q ^ b1_q;
      OP_XNOR: res = ~(a1_q ^ b1_q);
      OP_NOTA: res = ~a1_q;
      default: res = a1_q;
    endcase

    v1_d   = v1_q;
    a1_d   = a1_q;
    b1_d   = b1_q;
    op1_d  = op1_q;
    v2_d   = v2_q;
    r_d    = r_q;
    zero_d = zero_q;
    ones_d = ones_q;
    cnt_d  = cnt_q;

    if (ld1) begin
      v1_d = in_valid;
      if (in_valid) begin
        a1_d  = a;
        b1_d  = b;
        op1_d = op_e'(op);
      end
    end

    // A bubble moving into stage 2 clears v2 but leaves r/zero/ones as they were.
    if (ld2) begin
      v2_d = v1_q;
      if (v1_q) begin
        r_d    = res;
        zero_d = (res == '0);
        ones_d = (res == '1);
      end
    end

    if (v2_q && out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      op1_q  <= OP_AND;
      v2_q   <= 1'b0;
      r_q    <= '0;
      zero_q <= 1'b1;
      ones_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      op1_q  <= op1_d;
      v2_q   <= v2_d;
      r_q    <= r_d;
      zero_q <= zero_d;
      ones_q <= ones_d;
      cnt_q  <= cnt_d;
    end
  end

  assign in_ready  = ld1;
  assign out_valid = v2_q;
  assign r         = r_q;
  assign zero      = zero_q;
  assign ones      = ones_q;
  assign op_count  = cnt_q;

endmodule
